alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared combinational ALU: round-robin
// arbitration, operand capture, one registered result returned to the owner.
module alu_share_arbiter #(
  parameter int FIRST_GRANT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_aluc,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_aluc,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_s,
  output logic        rsp_z,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_s,
  input  logic        alu_z,
  output logic        busy,
  output logic        grant_id
);

  localparam logic       FG     = (FIRST_GRANT != 0);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        rr_q, rr_d;
  logic        grant_q, grant_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  aluc_q, aluc_d;
  logic [31:0] s_q, s_d;
  logic        z_q, z_d;

  logic any_vld;
  logic winner;
  logic accept;
  logic rsp_rdy_g;

  always_comb begin
    any_vld   = req0_valid | req1_valid;
    // rr_q only matters under contention; a lone requester always wins
    winner    = (req0_valid & req1_valid) ? rr_q : req1_valid;
    accept    = (state_q == S_IDLE) && any_vld;
    rsp_rdy_g = grant_q ? rsp1_ready : rsp0_ready;

    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    aluc_d  = aluc_q;
    s_d     = s_q;
    z_d     = z_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          grant_d = winner;
          a_d     = winner ? req1_a    : req0_a;
          b_d     = winner ? req1_b    : req0_b;
          aluc_d  = winner ? req1_aluc : req0_aluc;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        s_d     = alu_s;
        z_d     = alu_z;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_rdy_g) begin
          rr_d    = ~grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= FG;
      grant_q <= FG;
      a_q     <= '0;
      b_q     <= '0;
      aluc_q  <= '0;
      s_q     <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      aluc_q  <= aluc_d;
      s_q     <= s_d;
      z_q     <= z_d;
    end
  end

  assign req0_ready = accept & ~winner;
  assign req1_ready = accept &  winner;
  assign rsp0_valid = (state_q == S_RESP) & ~grant_q;
  assign rsp1_valid = (state_q == S_RESP) &  grant_q;
  assign rsp_s      = s_q;
  assign rsp_z      = z_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_aluc   = aluc_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: stand-in ALU, transaction-level reference model
// compared every cycle, directed scenarios with literal results, random traffic.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rr0, rr1;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp_s, alu_a, alu_b, alu_s;
  logic        rsp_z, alu_z, busy, grant_id;
  logic [3:0]  alu_aluc;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.FIRST_GRANT(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_a(a0), .req0_b(b0), .req0_aluc(op0),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_a(a1), .req1_b(b1), .req1_aluc(op1),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr0), .rsp1_valid(rsp1_valid), .rsp1_ready(rr1),
    .rsp_s(rsp_s), .rsp_z(rsp_z), .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_s(alu_s), .alu_z(alu_z), .busy(busy), .grant_id(grant_id)
  );

  // Stand-in ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, others give 0
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_s = ref_alu(alu_a, alu_b, alu_aluc);
    alu_z = (alu_s == 32'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, owner, cycles since acceptance,
  // and the requester preferred on contention (the other one of the last completion).
  logic        m_known = 1'b0;
  logic        m_act, m_own, m_pref, m_gid, m_rz;
  int          m_age;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_op;
  logic        e_rdy0, e_rdy1, e_w;

  always @(negedge clk) begin
    if (m_known) begin
      e_rdy0 = 1'b0;
      e_rdy1 = 1'b0;
      e_w    = (v0 && v1) ? m_pref : v1;
      if (!m_act && (v0 || v1)) begin
        e_rdy0 = !e_w;
        e_rdy1 = e_w;
      end
      chk("m_busy", busy, m_act);
      chk("m_req0_ready", req0_ready, e_rdy0);
      chk("m_req1_ready", req1_ready, e_rdy1);
      chk("m_rsp0_valid", rsp0_valid, m_act && m_age >= 1 && !m_own);
      chk("m_rsp1_valid", rsp1_valid, m_act && m_age >= 1 && m_own);
      chk("m_grant_id", grant_id, m_gid);
      chk("m_alu_a", alu_a, m_a);
      chk("m_alu_b", alu_b, m_b);
      chk("m_alu_aluc", alu_aluc, m_op);
      if (m_act && m_age >= 1) begin
        chk("m_rsp_s", rsp_s, m_res);
        chk("m_rsp_z", rsp_z, m_rz);
      end
    end
    if (rst) begin
      m_known = 1'b1;
      m_act = 1'b0; m_pref = 1'b0; m_gid = 1'b0; m_age = 0;
      m_a = '0; m_b = '0; m_op = '0;
    end else if (m_known) begin
      if (!m_act && (v0 || v1)) begin
        m_act = 1'b1;
        m_own = (v0 && v1) ? m_pref : v1;
        m_gid = m_own;
        m_age = 0;
        m_a   = m_own ? a1 : a0;
        m_b   = m_own ? b1 : b0;
        m_op  = m_own ? op1 : op0;
        m_res = ref_alu(m_a, m_b, m_op);
        m_rz  = (m_res == 32'd0);
      end else if (m_act) begin
        if (m_age >= 1 && (m_own ? rr1 : rr0)) begin
          m_act  = 1'b0;
          m_pref = !m_own;
        end else if (m_age < 1000) begin
          m_age++;
        end
      end
    end
  end

  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (n == 0) begin v0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    else        begin v1 = 1'b1; a1 = a; b1 = b; op1 = op; end
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if ((n == 0) ? req0_ready : req1_ready) got = 1'b1;
    end
    chk("issue_accepted", got, 1'b1);
    @(posedge clk); #1;
    if (n == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input logic [31:0] es, input logic ez,
                          input string nm, output int cnt);
    logic got;
    got = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      cnt++;
      if ((n == 0) ? rsp0_valid : rsp1_valid) got = 1'b1;
    end
    chk({nm, "_seen"}, got, 1'b1);
    if (got) begin
      chk({nm, "_s"}, rsp_s, es);
      chk({nm, "_z"}, rsp_z, ez);
    end
  endtask

  task automatic wait_idle();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (!busy) got = 1'b1;
    end
    chk("wait_idle", got, 1'b1);
  endtask

  initial begin
    int          cnt, first, nw;
    logic        got0, got1, drop0, drop1;
    logic [31:0] s_hold;
    int          wins [6];

    rst = 1'b1; v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_grant", grant_id, 1'b0);
    chk("reset_rsp0v", rsp0_valid, 1'b0);
    chk("reset_rsp1v", rsp1_valid, 1'b0);
    chk("reset_rsp_s", rsp_s, 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);

    // Single op, 5 + 3
    rr0 = 1'b1; rr1 = 1'b1;
    issue(0, 32'd5, 32'd3, 4'd0);
    wait_rsp(0, 32'd8, 1'b0, "single", cnt);
    chk("single_latency", cnt, 32'd2);
    chk("single_rsp1_quiet", rsp1_valid, 1'b0);
    wait_idle();

    // Contention from reset: SUB 7-7 on req0, XOR on req1
    @(posedge clk); #1;
    rst = 1'b1;
    v0 = 1'b1; a0 = 32'd7; b0 = 32'd7; op0 = 4'd1;
    v1 = 1'b1; a1 = 32'hF0F0_0000; b1 = 32'h0000_0F0F; op1 = 4'd4;
    @(posedge clk); #1 rst = 1'b0;
    first = -1; got0 = 0; got1 = 0; drop0 = 0; drop1 = 0;
    for (int c = 0; c < 40 && !(got0 && got1); c++) begin
      @(negedge clk);
      if (req0_ready) begin if (first < 0) first = 0; drop0 = 1'b1; end
      if (req1_ready) begin if (first < 0) first = 1; drop1 = 1'b1; end
      if (rsp0_valid && !got0) begin
        got0 = 1'b1;
        chk("cont_r0_s", rsp_s, 32'd0);
        chk("cont_r0_z", rsp_z, 1'b1);
      end
      if (rsp1_valid && !got1) begin
        got1 = 1'b1;
        chk("cont_r1_s", rsp_s, 32'hF0F0_0F0F);
        chk("cont_r1_z", rsp_z, 1'b0);
      end
      @(posedge clk); #1;
      if (drop0) v0 = 1'b0;
      if (drop1) v1 = 1'b0;
    end
    chk("cont_first", first, 32'd0);
    chk("cont_got0", got0, 1'b1);
    chk("cont_got1", got1, 1'b1);
    wait_idle();

    // Fairness with both valid continuously
    @(posedge clk); #1;
    v0 = 1'b1; a0 = 32'd11; b0 = 32'd4; op0 = 4'd0;
    v1 = 1'b1; a1 = 32'd9;  b1 = 32'd2; op1 = 4'd1;
    nw = 0;
    for (int c = 0; c < 80 && nw < 6; c++) begin
      @(negedge clk);
      if (req0_ready) begin wins[nw] = 0; nw++; end
      else if (req1_ready) begin wins[nw] = 1; nw++; end
      @(posedge clk); #1;
      if (nw > 0 && (req0_ready || req1_ready || busy)) chk("fair_gid", grant_id, wins[nw-1]);
      if (nw == 6) begin v0 = 1'b0; v1 = 1'b0; end
    end
    chk("fair_count", nw, 32'd6);
    for (int k = 0; k < 6; k++) chk("fair_order", wins[k], k % 2);
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();

    // Response backpressure on requester 1
    rr1 = 1'b0;
    issue(1, 32'd10, 32'd20, 4'd0);
    wait_rsp(1, 32'd30, 1'b0, "bp", cnt);
    s_hold = rsp_s;
    @(posedge clk); #1;
    v0 = 1'b1; a0 = 32'd3; b0 = 32'd3; op0 = 4'd3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp1v", rsp1_valid, 1'b1);
      chk("bp_hold_s", rsp_s, s_hold);
      chk("bp_busy", busy, 1'b1);
      chk("bp_rdy0", req0_ready, 1'b0);
      chk("bp_rdy1", req1_ready, 1'b0);
      @(posedge clk); #1;
    end
    rr1 = 1'b1;
    @(negedge clk);
    chk("bp_last_rsp1v", rsp1_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_done_busy", busy, 1'b0);
    chk("bp_done_rsp1v", rsp1_valid, 1'b0);
    chk("bp_waiting_served", req0_ready, 1'b1);
    @(posedge clk); #1 v0 = 1'b0;
    wait_idle();

    // Reset while in EXEC
    issue(1, 32'h8000_0000, 32'd4, 4'd7);
    chk("abort_in_exec", busy, 1'b1);
    chk("abort_gid_before", grant_id, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_gid", grant_id, 1'b0);
    chk("abort_rsp0v", rsp0_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_rsp1v", rsp1_valid, 1'b0);
      @(negedge clk);
    end

    // Shift pass-through on requester 1
    issue(1, 32'h8000_0000, 32'd4, 4'd7);
    wait_rsp(1, 32'hF800_0000, 1'b0, "sra", cnt);
    issue(1, 32'd1, 32'd31, 4'd5);
    wait_rsp(1, 32'h8000_0000, 1'b0, "sll", cnt);
    wait_idle();

    // Random traffic including unsupported codes, dropped valids, stray readys, resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 299) == 0);
      v0  = ($urandom_range(0, 2) != 0);
      v1  = ($urandom_range(0, 2) != 0);
      rr0 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0);
      a0  = $urandom; b0 = ($urandom_range(0, 1) != 0) ? $urandom : a0;
      a1  = $urandom; b1 = $urandom_range(0, 40);
      op0 = 4'($urandom_range(0, 15));
      op1 = 4'($urandom_range(0, 15));
    end
    @(posedge clk); #1;
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
